// File: rtl/mult_div_unit_pkg.sv
// rtl/mult_div_unit_pkg.sv - shared op encodings, states and widths for the mult/div engine
package mult_div_unit_pkg;

  localparam int MD_WORD  = 32;
  localparam int MD_DWORD = 2 * MD_WORD;

  typedef enum logic [1:0] {
    MD_MULT  = 2'b00,
    MD_MULTU = 2'b01,
    MD_DIV   = 2'b10,
    MD_DIVU  = 2'b11
  } md_op_e;

  typedef enum logic [1:0] {
    MD_IDLE = 2'b00,
    MD_RUN  = 2'b01,
    MD_DONE = 2'b10
  } md_state_e;

  function automatic logic md_is_div(input logic [1:0] op);
    return (op == MD_DIV) || (op == MD_DIVU);
  endfunction

  function automatic logic md_is_signed(input logic [1:0] op);
    return (op == MD_MULT) || (op == MD_DIV);
  endfunction

endpackage

// File: rtl/md_div_step.sv
// rtl/md_div_step.sv - one combinational restoring-division step
module md_div_step #(
  parameter int XLEN = 32
) (
  input  logic [XLEN:0]   rem_shifted,
  input  logic [XLEN-1:0] divisor,
  output logic [XLEN-1:0] rem_next,
  output logic            q_bit
);

  logic [XLEN-1:0] diff;

  // The shifted remainder is always below 2*divisor, so a successful
  // subtraction always fits back into XLEN bits.
  always_comb begin
    q_bit    = (rem_shifted >= {1'b0, divisor});
    diff     = rem_shifted[XLEN-1:0] - divisor;
    rem_next = q_bit ? diff : rem_shifted[XLEN-1:0];
  end

endmodule

// File: rtl/mult_div_unit.sv
// rtl/mult_div_unit.sv - iterative radix-2 multiply/divide engine feeding the hi/lo register
module mult_div_unit
  import mult_div_unit_pkg::*;
#(
  parameter int XLEN = MD_WORD
) (
  input  logic              clk_cpu,
  input  logic              reset_n,
  input  logic              start,
  input  logic [1:0]        op,
  input  logic [XLEN-1:0]   rs_data,
  input  logic [XLEN-1:0]   rt_data,
  input  logic              flush,
  output logic              busy,
  output logic              hilo_wr_en,
  output logic [2*XLEN-1:0] hilo_wr_data
);

  localparam int CNT_W = $clog2(XLEN) + 1;

  md_state_e         state, state_next;
  logic [CNT_W-1:0]  counter;
  logic              is_div_r;
  logic              neg_res;
  logic              neg_rem;
  logic              div_zero;
  logic [2*XLEN-1:0] acc, acc_next;
  logic [XLEN-1:0]   rem_r;
  logic [XLEN-1:0]   opnd;

  logic              accept;
  logic              last_step;
  logic              sign_a, sign_b;
  logic [XLEN-1:0]   mag_a, mag_b;
  logic [XLEN:0]     mul_sum;
  logic [XLEN:0]     div_rem_shifted;
  logic [XLEN-1:0]   div_rem_next;
  logic              q_bit;
  logic [XLEN-1:0]   quot_next;
  logic [XLEN-1:0]   rem_final, quot_final;
  logic [2*XLEN-1:0] result;

  function automatic logic [XLEN-1:0] magnitude(input logic [XLEN-1:0] x, input logic neg);
    return neg ? -x : x;
  endfunction

  always_ff @(posedge clk_cpu or negedge reset_n) begin
    if (!reset_n) begin
      state <= MD_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      MD_IDLE: if (start && !flush) state_next = MD_RUN;
      MD_RUN: begin
        if (flush)          state_next = MD_IDLE;
        else if (last_step) state_next = MD_DONE;
      end
      MD_DONE: state_next = MD_IDLE;
      default: state_next = MD_IDLE;
    endcase
  end

  always_comb begin
    busy       = (state != MD_IDLE);
    hilo_wr_en = (state == MD_DONE);
  end

  md_div_step #(.XLEN(XLEN)) u_div_step (
    .rem_shifted (div_rem_shifted),
    .divisor     (opnd),
    .rem_next    (div_rem_next),
    .q_bit       (q_bit)
  );

  always_comb begin
    accept    = (state == MD_IDLE) && start && !flush;
    last_step = (counter == CNT_W'(1));
    sign_a    = md_is_signed(op) && rs_data[XLEN-1];
    sign_b    = md_is_signed(op) && rt_data[XLEN-1];
    mag_a     = magnitude(rs_data, sign_a);
    mag_b     = magnitude(rt_data, sign_b);

    // Multiplier sits in the low half and drains out as the product shifts in.
    mul_sum         = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, opnd} : '0);
    div_rem_shifted = {rem_r, acc[XLEN-1]};
    quot_next       = {acc[XLEN-2:0], q_bit};

    if (is_div_r) begin
      acc_next = {acc[2*XLEN-1:XLEN], quot_next};
    end else begin
      acc_next = {mul_sum, acc[XLEN-1:1]};
    end

    rem_final  = neg_rem ? -div_rem_next : div_rem_next;
    quot_final = div_zero ? '1 : (neg_res ? -quot_next : quot_next);
    if (is_div_r) begin
      result = {rem_final, quot_final};
    end else begin
      result = neg_res ? -acc_next : acc_next;
    end
  end

  always_ff @(posedge clk_cpu or negedge reset_n) begin
    if (!reset_n) begin
      counter      <= '0;
      is_div_r     <= 1'b0;
      neg_res      <= 1'b0;
      neg_rem      <= 1'b0;
      div_zero     <= 1'b0;
      acc          <= '0;
      rem_r        <= '0;
      opnd         <= '0;
      hilo_wr_data <= '0;
    end else if (accept) begin
      counter  <= CNT_W'(XLEN);
      is_div_r <= md_is_div(op);
      neg_res  <= sign_a ^ sign_b;
      neg_rem  <= sign_a;
      div_zero <= md_is_div(op) && (rt_data == '0);
      rem_r    <= '0;
      if (md_is_div(op)) begin
        acc  <= {{XLEN{1'b0}}, mag_a};
        opnd <= mag_b;
      end else begin
        acc  <= {{XLEN{1'b0}}, mag_b};
        opnd <= mag_a;
      end
    end else if (state == MD_RUN) begin
      if (flush) begin
        counter <= '0;
      end else begin
        counter <= counter - CNT_W'(1);
        acc     <= acc_next;
        rem_r   <= div_rem_next;
        if (last_step) hilo_wr_data <= result;
      end
    end
  end

endmodule

// File: tb/tb_mult_div_unit.sv
// tb/tb_mult_div_unit.sv - scoreboard bench for mult_div_unit against an arithmetic reference model
module tb_mult_div_unit;

  logic        clk_cpu = 1'b0;
  logic        reset_n = 1'b0;
  logic        start   = 1'b0;
  logic        flush   = 1'b0;
  logic [1:0]  op      = 2'b00;
  logic [31:0] rs_data = '0;
  logic [31:0] rt_data = '0;
  logic        busy;
  logic        hilo_wr_en;
  logic [63:0] hilo_wr_data;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  logic [63:0] exp_data_q[$];
  int          exp_cyc_q[$];
  string       exp_name_q[$];

  mult_div_unit #(.XLEN(32)) dut (
    .clk_cpu      (clk_cpu),
    .reset_n      (reset_n),
    .start        (start),
    .op           (op),
    .rs_data      (rs_data),
    .rt_data      (rt_data),
    .flush        (flush),
    .busy         (busy),
    .hilo_wr_en   (hilo_wr_en),
    .hilo_wr_data (hilo_wr_data)
  );

  always #5 clk_cpu = ~clk_cpu;
  always @(posedge clk_cpu) cyc++;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference: plain 64-bit arithmetic on the architectural operand values.
  function automatic logic [63:0] model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, q, r;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (o)
      2'b00: return 64'(sa * sb);
      2'b01: return {32'b0, a} * {32'b0, b};
      2'b10: begin
        if (b == 32'h0) return {a, 32'hFFFF_FFFF};
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'h0, 32'h8000_0000};
        q = sa / sb;
        r = sa % sb;
        return {r[31:0], q[31:0]};
      end
      default: begin
        if (b == 32'h0) return {a, 32'hFFFF_FFFF};
        return {a % b, a / b};
      end
    endcase
  endfunction

  always @(posedge clk_cpu) begin
    #1;
    if (hilo_wr_en === 1'b1) begin
      if (exp_data_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write: got %h expected no write", hilo_wr_data);
      end else begin
        check({exp_name_q[0], " data"}, hilo_wr_data, exp_data_q[0]);
        check({exp_name_q[0], " latency"}, 64'(cyc), 64'(exp_cyc_q[0]));
        check({exp_name_q[0], " busy_in_done"}, 64'(busy), 64'(1));
        void'(exp_data_q.pop_front());
        void'(exp_cyc_q.pop_front());
        void'(exp_name_q.pop_front());
      end
    end
  end

  task automatic wait_idle();
    int n = 0;
    @(negedge clk_cpu);
    while (busy && n < 200) begin
      @(negedge clk_cpu);
      n++;
    end
    if (busy) begin
      checks++;
      errors++;
      $display("FAIL wait_idle: busy still %0d expected 0 within 200 cycles", busy);
    end
  endtask

  task automatic issue(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                       input string name, input bit push);
    wait_idle();
    start   = 1'b1;
    op      = o;
    rs_data = a;
    rt_data = b;
    @(posedge clk_cpu);
    #1;
    if (push) begin
      exp_data_q.push_back(model(o, a, b));
      exp_cyc_q.push_back(cyc + 32);
      exp_name_q.push_back(name);
    end
    check({name, " busy_after_start"}, 64'(busy), 64'(1));
    @(negedge clk_cpu);
    start = 1'b0;
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0: return 32'h0;
      1: return 32'h8000_0000;
      2: return 32'hFFFF_FFFF;
      3: return 32'h1;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    repeat (3) @(negedge clk_cpu);
    check("reset busy", 64'(busy), 64'(0));
    check("reset wr_en", 64'(hilo_wr_en), 64'(0));
    check("reset wr_data", hilo_wr_data, 64'h0);
    reset_n = 1'b1;

    issue(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "multu_max", 1'b1);
    issue(2'b00, 32'hFFFF_FFFD, 32'd7,         "mult_neg3x7", 1'b1);
    issue(2'b00, 32'h8000_0000, 32'h8000_0000, "mult_minxmin", 1'b1);
    issue(2'b10, 32'hFFFF_FFF9, 32'd2,         "div_neg7by2", 1'b1);
    issue(2'b11, 32'd100,       32'd7,         "divu_100by7", 1'b1);
    issue(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, "div_min_by_neg1", 1'b1);
    issue(2'b11, 32'd5,         32'd0,         "divu_5by0", 1'b1);
    issue(2'b10, 32'hFFFF_FFFB, 32'd0,         "div_neg5by0", 1'b1);
    issue(2'b10, 32'd7,         32'hFFFF_FFFE, "div_7by_neg2", 1'b1);
    wait_idle();
    check("busy_after_divzero", 64'(busy), 64'(0));

    for (int i = 0; i < 30; i++) begin
      issue(2'($urandom_range(0, 3)), pick(), pick(), $sformatf("rand%0d", i), 1'b1);
    end

    // start mid-RUN with fresh operands must not disturb the op in flight
    issue(2'b01, 32'd1234, 32'd5678, "start_ignored", 1'b1);
    repeat (5) @(negedge clk_cpu);
    start = 1'b1; op = 2'b11; rs_data = 32'd999; rt_data = 32'd3;
    @(negedge clk_cpu);
    start = 1'b0;

    // flush at RUN cycle 10 cancels with no write
    issue(2'b11, 32'd1000, 32'd9, "flushed", 1'b0);
    repeat (9) @(negedge clk_cpu);
    flush = 1'b1;
    @(posedge clk_cpu);
    #1;
    check("flush busy", 64'(busy), 64'(0));
    check("flush wr_en", 64'(hilo_wr_en), 64'(0));
    @(negedge clk_cpu);
    flush = 1'b0;
    repeat (40) @(negedge clk_cpu);

    // flush with start in IDLE: start ignored
    wait_idle();
    start = 1'b1; flush = 1'b1; op = 2'b00; rs_data = 32'd3; rt_data = 32'd4;
    @(posedge clk_cpu);
    #1;
    check("flush_start busy", 64'(busy), 64'(0));
    @(negedge clk_cpu);
    start = 1'b0; flush = 1'b0;
    repeat (40) @(negedge clk_cpu);

    // flush during DONE: write still lands
    issue(2'b00, 32'hFFFF_0000, 32'd12345, "flush_in_done", 1'b1);
    for (int n = 0; n < 60 && hilo_wr_en !== 1'b1; n++) @(negedge clk_cpu);
    check("done_reached", 64'(hilo_wr_en), 64'(1));
    flush = 1'b1;
    @(negedge clk_cpu);
    flush = 1'b0;
    check("idle_after_done", 64'(busy), 64'(0));

    // asynchronous reset mid-RUN clears every output at once
    issue(2'b01, 32'h1234_5678, 32'h9ABC_DEF0, "reset_mid_run", 1'b0);
    repeat (5) @(negedge clk_cpu);
    #2;
    reset_n = 1'b0;
    #1;
    check("async_reset busy", 64'(busy), 64'(0));
    check("async_reset wr_en", 64'(hilo_wr_en), 64'(0));
    check("async_reset wr_data", hilo_wr_data, 64'h0);
    @(negedge clk_cpu);
    reset_n = 1'b1;
    repeat (40) @(negedge clk_cpu);

    issue(2'b11, 32'hDEAD_BEEF, 32'd17, "after_reset", 1'b1);
    wait_idle();
    repeat (2) @(negedge clk_cpu);
    check("scoreboard_drained", 64'(exp_data_q.size()), 64'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
